// File: rtl/alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue side of the per-container ALU handshake in an RMT action
//            stage. Captures one PHV plus one action word and selects the ALU
//            operands from PHV containers or the immediate field. Issues the
//            action to the ALU, writes the returned container into the
//            destination slot and forwards the updated PHV downstream.
//            A response watchdog abandons a silent ALU after TIMEOUT_CYCLES.
// Ports    :
//   clk, rst_n                      stage clock, async active-low reset
//   phv_in/action_in/in_valid       upstream PHV + action, in_ready back
//   alu_action/alu_action_valid     one-cycle issue strobe to the ALU
//   alu_op1..alu_op4                registered operands
//   alu_ready                       ALU idle
//   alu_result/alu_result_valid     ALU response, alu_ready_in back
//   phv_out/out_valid/out_ready     downstream PHV handshake
//   timeout_err                     one-cycle pulse on watchdog expiry
//   issue_cnt / timeout_cnt         wrapping / saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int NUM_CONTAINERS = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ACTION_LEN     = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]                action_in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [ACTION_LEN-1:0]                alu_action,
    output logic                                 alu_action_valid,
    output logic [DATA_WIDTH-1:0]                alu_op1,
    output logic [DATA_WIDTH-1:0]                alu_op2,
    output logic [DATA_WIDTH-1:0]                alu_op3,
    output logic [DATA_WIDTH-1:0]                alu_op4,
    input  logic                                 alu_ready,
    input  logic [DATA_WIDTH-1:0]                alu_result,
    input  logic                                 alu_result_valid,
    output logic                                 alu_ready_in,
    output logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 timeout_err,
    output logic [15:0]                          issue_cnt,
    output logic [15:0]                          timeout_cnt
);

    // Only the low index bits address a container; the rest of each 3-bit
    // field is ignored for smaller PHVs.
    localparam int c_IDX_W = (NUM_CONTAINERS > 1) ? $clog2(NUM_CONTAINERS) : 1;
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES);

    // Field LSB positions inside the action word.
    localparam int c_SRC1_LSB = 53;
    localparam int c_SRC2_LSB = 50;
    localparam int c_SRC3_LSB = 47;
    localparam int c_DST_LSB  = 44;
    localparam int c_SRC4_LSB = 41;

    localparam logic [7:0] c_OP_NOP = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DATA_WIDTH-1:0]   w_cont_in [NUM_CONTAINERS];
    logic [DATA_WIDTH-1:0]   r_phv     [NUM_CONTAINERS];

    logic [ACTION_LEN-1:0]   r_action;
    logic [DATA_WIDTH-1:0]   r_op1;
    logic [DATA_WIDTH-1:0]   r_op2;
    logic [DATA_WIDTH-1:0]   r_op3;
    logic [DATA_WIDTH-1:0]   r_op4;
    logic [15:0]             r_issue_cnt;
    logic [15:0]             r_timeout_cnt;
    logic [c_WD_W-1:0]       r_wd;

    logic [7:0]              w_opcode;
    logic [c_IDX_W-1:0]      w_src1;
    logic [c_IDX_W-1:0]      w_src2;
    logic [c_IDX_W-1:0]      w_src3;
    logic [c_IDX_W-1:0]      w_src4;
    logic [c_IDX_W-1:0]      w_dst;
    logic [31:0]             w_imm;
    logic [DATA_WIDTH-1:0]   w_op2_sel;
    logic                    w_capture;
    logic                    w_issue;
    logic                    w_wr_result;
    logic                    w_timeout;
    logic                    w_wd_expired;

    // ------------------------------------------------------------------
    // PHV pack / unpack
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CONTAINERS; gi++) begin : g_cont
            assign w_cont_in[gi]                          = phv_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign phv_out[gi*DATA_WIDTH +: DATA_WIDTH]   = r_phv[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Action field decode (on the incoming word, used at capture)
    // ------------------------------------------------------------------
    assign w_opcode = action_in[63:56];
    assign w_src1   = action_in[c_SRC1_LSB +: c_IDX_W];
    assign w_src2   = action_in[c_SRC2_LSB +: c_IDX_W];
    assign w_src3   = action_in[c_SRC3_LSB +: c_IDX_W];
    assign w_src4   = action_in[c_SRC4_LSB +: c_IDX_W];
    assign w_imm    = action_in[40:9];

    // Destination comes from the held action so it stays valid through WAIT.
    assign w_dst    = r_action[c_DST_LSB +: c_IDX_W];

    // op2: full immediate for immediate-form opcodes, the 5-bit register
    // index held in imm[4:0] for stateful opcodes, otherwise a container.
    always_comb begin
        w_op2_sel = w_cont_in[w_src2];
        case (w_opcode)
            8'h09, 8'h0A, 8'h0E: w_op2_sel = DATA_WIDTH'(w_imm);
            8'h07, 8'h08, 8'h0B, 8'h0C: w_op2_sel = DATA_WIDTH'(w_imm[4:0]);
            default: w_op2_sel = w_cont_in[w_src2];
        endcase
    end

    assign w_wd_expired = (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        in_ready         = 1'b0;
        alu_action_valid = 1'b0;
        alu_ready_in     = 1'b0;
        out_valid        = 1'b0;
        w_capture        = 1'b0;
        w_issue          = 1'b0;
        w_wr_result      = 1'b0;
        w_timeout        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (w_opcode == c_OP_NOP) ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Watchdog is not armed here: a busy ALU may stall forever.
                if (alu_ready) begin
                    alu_action_valid = 1'b1;
                    w_issue          = 1'b1;
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                alu_ready_in = 1'b1;
                // A result arriving on the expiry cycle takes priority.
                if (alu_result_valid) begin
                    w_wr_result = 1'b1;
                    w_state_nxt = S_OUT;
                end else if (w_wd_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign timeout_err = w_timeout;

    // ------------------------------------------------------------------
    // Datapath: capture, result write-back, counters, watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONTAINERS; i++) begin
                r_phv[i] <= '0;
            end
            r_action      <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_op3         <= '0;
            r_op4         <= '0;
            r_issue_cnt   <= '0;
            r_timeout_cnt <= '0;
            r_wd          <= '0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < NUM_CONTAINERS; i++) begin
                    r_phv[i] <= w_cont_in[i];
                end
                r_action <= action_in;
                r_op1    <= w_cont_in[w_src1];
                r_op2    <= w_op2_sel;
                r_op3    <= w_cont_in[w_src3];
                r_op4    <= w_cont_in[w_src4];
            end

            if (w_wr_result) begin
                r_phv[w_dst] <= alu_result;
            end

            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end

            if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end

            // Counts cycles spent in WAIT; cleared whenever WAIT is left or
            // not yet entered so each wait starts from zero.
            if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
                r_wd <= r_wd + c_WD_W'(1);
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign alu_action  = r_action;
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign alu_op3     = r_op3;
    assign alu_op4     = r_op4;
    assign issue_cnt   = r_issue_cnt;
    assign timeout_cnt = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. Table of action vectors
//            plus hand-written sequences for ALU stall, output backpressure,
//            watchdog expiry, result-at-expiry and asynchronous reset.
//            Expected PHVs go into a scoreboard queue when driven and are
//            compared when the DUT hands phv_out downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int NC = 8;
    localparam int DW = 32;
    localparam int AL = 64;
    localparam int TO = 8;
    localparam int PW = NC*DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phv_in;
    logic [AL-1:0] action_in;
    logic          in_valid;
    logic          in_ready;
    logic [AL-1:0] alu_action;
    logic          alu_action_valid;
    logic [DW-1:0] alu_op1, alu_op2, alu_op3, alu_op4;
    logic          alu_ready;
    logic [DW-1:0] alu_result;
    logic          alu_result_valid;
    logic          alu_ready_in;
    logic [PW-1:0] phv_out;
    logic          out_valid;
    logic          out_ready;
    logic          timeout_err;
    logic [15:0]   issue_cnt;
    logic [15:0]   timeout_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .NUM_CONTAINERS (NC),
        .DATA_WIDTH     (DW),
        .ACTION_LEN     (AL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .action_in        (action_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_action       (alu_action),
        .alu_action_valid (alu_action_valid),
        .alu_op1          (alu_op1),
        .alu_op2          (alu_op2),
        .alu_op3          (alu_op3),
        .alu_op4          (alu_op4),
        .alu_ready        (alu_ready),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .alu_ready_in     (alu_ready_in),
        .phv_out          (phv_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .timeout_err      (timeout_err),
        .issue_cnt        (issue_cnt),
        .timeout_cnt      (timeout_cnt)
    );

    typedef struct {
        string         name;
        logic [PW-1:0] phv;
        logic [AL-1:0] act;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] op4;
        logic [DW-1:0] res;
        logic [PW-1:0] exp_phv;
    } vec_t;

    int            tests = 0;
    int            fails = 0;
    int            strobe_cnt = 0;
    int            to_pulse_cnt = 0;
    logic [PW-1:0] exp_q[$];
    vec_t          vecs[7];
    logic [15:0]   exp_issue = 16'd0;

    function automatic logic [AL-1:0] mk_act(input logic [7:0] op, input logic [2:0] s1,
                                             input logic [2:0] s2, input logic [2:0] s3,
                                             input logic [2:0] d, input logic [2:0] s4,
                                             input logic [31:0] imm);
        return {op, s1, s2, s3, d, s4, imm, 9'h0};
    endfunction

    function automatic logic [PW-1:0] set_c(input logic [PW-1:0] p, input int idx, input logic [DW-1:0] v);
        p[idx*DW +: DW] = v;
        return p;
    endfunction

    function automatic logic [DW-1:0] get_c(input logic [PW-1:0] p, input int idx);
        return p[idx*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired, got no event want event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_action_valid) strobe_cnt++;
            if (timeout_err) to_pulse_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_phv_out");
                end else begin
                    check("phv_out", phv_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_in(input vec_t v);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) bound_fail({v.name, "_accept"});
        in_valid  = 1'b1;
        phv_in    = v.phv;
        action_in = v.act;
        exp_q.push_back(v.exp_phv);
        tick();
        in_valid  = 1'b0;
    endtask

    // mode 0: return result on first WAIT cycle; 1: never return;
    // 2: return on the watchdog expiry cycle.
    task automatic finish_vec(input vec_t v, input int mode);
        int n = 0;
        if (v.act[63:56] == 8'h00) begin
            @(negedge clk);
            check({v.name, "_no_strobe"}, alu_action_valid, 1'b0);
            check({v.name, "_out_valid"}, out_valid, 1'b1);
        end else begin
            @(negedge clk);
            while (!alu_action_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!alu_action_valid) begin
                bound_fail({v.name, "_strobe"});
            end else begin
                check({v.name, "_op1"}, alu_op1, v.op1);
                check({v.name, "_op2"}, alu_op2, v.op2);
                check({v.name, "_op4"}, alu_op4, v.op4);
                check({v.name, "_action"}, alu_action, v.act);
            end
            tick();
            if (mode == 0) begin
                alu_result       = v.res;
                alu_result_valid = 1'b1;
                @(negedge clk);
                check({v.name, "_alu_ready_in"}, alu_ready_in, 1'b1);
                tick();
                alu_result_valid = 1'b0;
            end else if (mode == 1) begin
                for (int k = 1; k <= TO; k++) begin
                    @(negedge clk);
                    check($sformatf("%s_timeout_err_c%0d", v.name, k), timeout_err, (k == TO));
                    if (k < TO) tick();
                end
            end else begin
                repeat (TO - 1) tick();
                alu_result       = v.res;
                alu_result_valid = 1'b1;
                @(negedge clk);
                check({v.name, "_no_err_at_expiry"}, timeout_err, 1'b0);
                tick();
                alu_result_valid = 1'b0;
            end
        end
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) bound_fail({v.name, "_out_valid_wait"});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) bound_fail({name, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [PW-1:0] base;
        logic [PW-1:0] p;
        vec_t          v;
        int            s0;
        int            t0;

        in_valid         = 1'b0;
        phv_in           = '0;
        action_in        = '0;
        alu_ready        = 1'b1;
        alu_result       = '0;
        alu_result_valid = 1'b0;
        out_ready        = 1'b1;

        base = '0;
        for (int i = 0; i < NC; i++) base = set_c(base, i, 32'h1000_0000 * (i + 1) + 32'h11 * i);

        // Add: C0=5, C1=7, dst=2
        p = set_c(set_c(base, 0, 32'd5), 1, 32'd7);
        vecs[0] = '{"add", p, mk_act(8'h01, 3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 32'h0),
                    32'd5, 32'd7, get_c(p, 4), 32'd12, set_c(p, 2, 32'd12)};
        vecs[1] = '{"imm09", base, mk_act(8'h09, 3'd3, 3'd6, 3'd0, 3'd6, 3'd5, 32'h100),
                    get_c(base, 3), 32'h100, get_c(base, 5), 32'hDEAD_BEEF, set_c(base, 6, 32'hDEAD_BEEF)};
        vecs[2] = '{"stat0C", base, mk_act(8'h0C, 3'd7, 3'd1, 3'd2, 3'd0, 3'd7, 32'hFFFF_FFE3),
                    get_c(base, 7), 32'h3, get_c(base, 7), 32'h55, set_c(base, 0, 32'h55)};
        vecs[3] = '{"imm0E", base, mk_act(8'h0E, 3'd1, 3'd2, 3'd4, 3'd7, 3'd0, 32'hABCD_1234),
                    get_c(base, 1), 32'hABCD_1234, get_c(base, 0), 32'h7777, set_c(base, 7, 32'h7777)};
        vecs[4] = '{"reg05", base, mk_act(8'h05, 3'd2, 3'd4, 3'd1, 3'd3, 3'd6, 32'h0000_FFFF),
                    get_c(base, 2), get_c(base, 4), get_c(base, 6), 32'h1234, set_c(base, 3, 32'h1234)};
        vecs[5] = '{"bypass", p, mk_act(8'h00, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 32'hFFFF_FFFF),
                    32'h0, 32'h0, 32'h0, 32'h0, p};
        vecs[6] = '{"stat08", base, mk_act(8'h08, 3'd5, 3'd3, 3'd1, 3'd1, 3'd2, 32'h1234_567F),
                    get_c(base, 5), 32'h1F, get_c(base, 2), 32'hCAFE, set_c(base, 1, 32'hCAFE)};

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_alu_action_valid", alu_action_valid, 1'b0);
        check("rst_alu_ready_in", alu_ready_in, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_phv_out", phv_out, '0);
        check("rst_issue_cnt", issue_cnt, 16'd0);
        check("rst_timeout_cnt", timeout_cnt, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            s0 = strobe_cnt;
            send_in(vecs[i]);
            finish_vec(vecs[i], 0);
            drain(vecs[i].name);
            if (vecs[i].act[63:56] != 8'h00) exp_issue++;
            check({vecs[i].name, "_strobes"}, strobe_cnt - s0, (vecs[i].act[63:56] != 8'h00) ? 1 : 0);
            check({vecs[i].name, "_issue_cnt"}, issue_cnt, exp_issue);
        end

        // ALU stall: alu_ready low for 10 cycles
        alu_ready = 1'b0;
        s0 = strobe_cnt;
        send_in(vecs[0]);
        repeat (10) tick();
        check("stall_no_strobe", strobe_cnt - s0, 0);
        check("stall_in_ready", in_ready, 1'b0);
        alu_ready = 1'b1;
        finish_vec(vecs[0], 0);
        drain("stall");
        exp_issue++;
        check("stall_one_strobe", strobe_cnt - s0, 1);
        check("stall_issue_cnt", issue_cnt, exp_issue);

        // Downstream backpressure: out_ready low for 5 cycles
        out_ready = 1'b0;
        send_in(vecs[1]);
        finish_vec(vecs[1], 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_phv_stable_%0d", k), phv_out, vecs[1].exp_phv);
            check($sformatf("bp_out_valid_%0d", k), out_valid, 1'b1);
            check($sformatf("bp_in_ready_%0d", k), in_ready, 1'b0);
        end
        tick();
        out_ready = 1'b1;
        drain("bp");
        exp_issue++;

        // Watchdog expiry: PHV forwarded unchanged
        v = vecs[0];
        v.name = "tmo";
        v.exp_phv = v.phv;
        t0 = to_pulse_cnt;
        send_in(v);
        finish_vec(v, 1);
        drain("tmo");
        exp_issue++;
        check("tmo_pulses", to_pulse_cnt - t0, 1);
        check("tmo_timeout_cnt", timeout_cnt, 16'd1);
        check("tmo_issue_cnt", issue_cnt, exp_issue);

        // Result on the expiry cycle wins
        v = vecs[0];
        v.name = "race";
        t0 = to_pulse_cnt;
        send_in(v);
        finish_vec(v, 2);
        drain("race");
        exp_issue++;
        check("race_pulses", to_pulse_cnt - t0, 0);
        check("race_timeout_cnt", timeout_cnt, 16'd1);

        // Asynchronous reset in the middle of WAIT
        send_in(vecs[1]);
        @(negedge clk);
        check("mid_strobe", alu_action_valid, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_issue = 16'd0;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_alu_ready_in", alu_ready_in, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_timeout_err", timeout_err, 1'b0);
        check("mid_rst_alu_action", alu_action, '0);
        check("mid_rst_op1", alu_op1, '0);
        check("mid_rst_op2", alu_op2, '0);
        check("mid_rst_phv_out", phv_out, '0);
        check("mid_rst_issue_cnt", issue_cnt, 16'd0);
        check("mid_rst_timeout_cnt", timeout_cnt, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_in(vecs[2]);
        finish_vec(vecs[2], 0);
        drain("post_rst");
        exp_issue++;
        check("post_rst_issue_cnt", issue_cnt, exp_issue);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue side of the per-container ALU action/operand handshake inside an RMT action stage.
- Accepts one PHV plus one 64-bit action word and selects the ALU operands from PHV containers or the immediate field.
- Issues one action to the ALU, collects the returned container, writes it into the destination container and forwards the updated PHV downstream.
- Also runs a response watchdog and keeps issue/timeout counters.

Parameters:
- NUM_CONTAINERS, 8, number of 32-bit PHV containers (power of two, max 8).
- DATA_WIDTH, 32, container and operand width.
- ACTION_LEN, 64, action word width.
- TIMEOUT_CYCLES, 64, wait cycles before abandoning an ALU response (>=4).

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  asynchronous active-low reset.
- phv_in  in  NUM_CONTAINERS*DATA_WIDTH  input PHV; container i is bits [i*32+31:i*32].
- action_in  in  ACTION_LEN  action word.
- in_valid  in  1  PHV/action valid.
- in_ready  out  1  block can accept.
- alu_action  out  ACTION_LEN  action to ALU.
- alu_action_valid  out  1  one-cycle issue strobe.
- alu_op1, alu_op2, alu_op3, alu_op4  out  DATA_WIDTH each  operands.
- alu_ready  in  1  ALU idle (ALU ready_out).
- alu_result  in  DATA_WIDTH  ALU container output.
- alu_result_valid  in  1  ALU result strobe.
- alu_ready_in  out  1  result sink ready (to ALU ready_in).
- phv_out  out  NUM_CONTAINERS*DATA_WIDTH  updated PHV.
- out_valid  out  1  phv_out valid.
- out_ready  in  1  downstream ready.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- issue_cnt  out  16  actions issued, wraps at 0xFFFF->0.
- timeout_cnt  out  16  timeouts, saturates at 0xFFFF.

Behaviour:
Action fields:
- [63:56] opcode; [55:53] src1; [52:50] src2; [49:47] src3; [46:44] dst; [43:41] src4; [40:9] imm32.
- Index bits above log2(NUM_CONTAINERS) are ignored.
- alu_action = the captured action word, unmodified.

Operand selection (registered at capture):
- op1 = C[src1]; op3 = C[src3]; op4 = C[src4].
- op2 = imm32 for opcodes 0x09, 0x0A, 0x0E.
- op2 = {27'b0, imm32[4:0]} for stateful opcodes 0x07, 0x08, 0x0B, 0x0C.
- op2 = C[src2] otherwise.

FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: in_ready=1. On in_valid, capture phv_in into phv_reg, capture action and operands, and set in_ready=0 the next cycle.
  - opcode 0x00 goes to OUT (bypass, no issue, PHV unchanged).
  - Any other opcode goes to ISSUE.
- ISSUE: wait for alu_ready=1. In that cycle assert alu_action_valid for exactly 1 cycle, increment issue_cnt and go to WAIT.
  - The watchdog is not armed in ISSUE; waiting here is unbounded.
- WAIT: alu_ready_in=1; the watchdog counts up from 0 each cycle.
  - On alu_result_valid, write phv_reg[dst] <= alu_result and go to OUT.
  - On counter == TIMEOUT_CYCLES-1 with no result: pulse timeout_err, increment timeout_cnt (saturating), go to OUT with phv_reg unchanged.
  - If a result and expiry occur in the same cycle, the result wins and there is no error.
- OUT: out_valid=1 and phv_out = phv_reg.
  - phv_out is held stable while out_ready=0.
  - On out_ready go to IDLE; the next input can be accepted in the following cycle.
- alu_ready_in=0 in every state except WAIT. A late alu_result_valid outside WAIT is ignored.
- Operands and alu_action stay stable from capture until leaving WAIT.
- Throughput: one action per at least 4 cycles. Best-case latency from in_valid accept to out_valid is ALU latency + 3 cycles.

Reset (asynchronous, any state including mid-WAIT):
- FSM returns to IDLE.
- in_ready=1.
- alu_action_valid=0, alu_ready_in=0, out_valid=0, timeout_err=0.
- alu_action, operands, phv_out, both counters and the watchdog = 0.

Test Plan:
- Add: C0=5, C1=7, action opcode 0x01, src1=0, src2=1, dst=2, alu_ready=1. Expect one alu_action_valid with op1=5, op2=7. Return alu_result=12 -> phv_out C2=12, other containers unchanged, issue_cnt=1.
- Immediate and stateful operand select:
  - opcode 0x09 with imm32=0x100 -> op2=0x100.
  - opcode 0x0C with imm32=0xFFFFFFE3 -> op2=0x3.
  - op4 = C[src4] in both cases.
- Bypass: opcode 0x00 -> no alu_action_valid; out_valid in cycle 2 after accept; phv_out == phv_in; issue_cnt unchanged.
- Backpressure:
  - Hold alu_ready=0 for 10 cycles -> stays in ISSUE, exactly one strobe after release.
  - Hold out_ready=0 for 5 cycles -> phv_out stable and in_ready=0 throughout.
- Timeout: TIMEOUT_CYCLES=8, no result -> timeout_err pulse 8 cycles into WAIT, timeout_cnt=1, phv_out unchanged. A result asserted in that same 8th cycle -> no error, dst written.
- Reset mid-WAIT: assert rst_n=0 asynchronously -> outputs reach reset values without a clock edge. A new action after release issues normally, and issue_cnt restarts from 0.
